// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, baud arithmetic and vote helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_e;

    // Single source of truth for the bit period, shared with the transmitter.
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // 2-of-3 majority used to reject single-cycle noise around the bit centre.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for asynchronous inputs, resets to 1
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values of the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops; reset to 1 so an idle-high line never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver with mid-bit majority sampling and valid/ready output
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    input  logic                    uart_rx_ready,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break,
    output logic                    uart_rx_overrun
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CW             = $clog2(CYCLES_PER_BIT);
    localparam int BW             = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF_BIT);
    localparam logic [CW-1:0] CNT_S2   = CW'(HALF_BIT + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PAYLOAD_BITS - 1);

    logic rxd_s;

    uart_state_e state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [2:0]              samp_q, samp_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    fe_q, fe_d;
    logic                    brk_q, brk_d;
    logic                    ovr_q, ovr_d;

    logic vote_mid;
    logic vote_stop;
    logic sample_slot;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    // START/DATA decide at end of period from the three stored samples; STOP decides
    // on the third sample itself, so its third tap is the live synced line.
    assign vote_mid    = majority3(samp_q[2], samp_q[1], samp_q[0]);
    assign vote_stop   = majority3(samp_q[1], samp_q[0], rxd_s);
    assign sample_slot = (cnt_q == CNT_S0) || (cnt_q == CNT_S1) || (cnt_q == CNT_S2);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            samp_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            brk_q   <= brk_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame sequencing: start detect, start qualification, data bits, stop check, break hold-off.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rxd_s && uart_rx_en) state_d = START;
            START:     if (cnt_q == CNT_LAST) state_d = vote_mid ? IDLE : DATA;
            DATA:      if (cnt_q == CNT_LAST && bit_q == BIT_LAST) state_d = STOP;
            STOP:      if (cnt_q == CNT_S2) state_d = vote_stop ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxd_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Counters, sample/shift registers, output register and one-cycle status pulses.
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        samp_d  = samp_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        brk_d   = 1'b0;
        ovr_d   = 1'b0;

        // An accept clears valid; a frame landing in the same cycle re-asserts it below.
        if (valid_q && uart_rx_ready) begin
            valid_d = 1'b0;
        end

        if ((state_q == START || state_q == DATA || state_q == STOP) && sample_slot) begin
            samp_d = {samp_q[1:0], rxd_s};
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            START, DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (state_q == DATA) begin
                        shift_d = {vote_mid, shift_q[PAYLOAD_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_S2) begin
                    cnt_d = '0;
                    if (vote_stop) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ovr_d   = valid_q && !uart_rx_ready;
                    end else if (shift_q == '0) begin
                        brk_d = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_frame_err = fe_q;
    assign uart_rx_break     = brk_q;
    assign uart_rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core (16 cycles per bit)
module tb_uart_rx_core;

    localparam int CLK_HZ   = 160000;
    localparam int BIT_RATE = 10000;
    localparam int PB       = 8;
    localparam int CPB      = CLK_HZ / BIT_RATE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uart_rxd = 1'b1;
    logic          uart_rx_en = 1'b1;
    logic          uart_rx_ready = 1'b0;
    logic [PB-1:0] uart_rx_data;
    logic          uart_rx_valid;
    logic          uart_rx_frame_err;
    logic          uart_rx_break;
    logic          uart_rx_overrun;

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .PAYLOAD_BITS (PB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_ready     (uart_rx_ready),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_break     (uart_rx_break),
        .uart_rx_overrun   (uart_rx_overrun)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fe    = 0;
    int n_brk   = 0;
    int n_ovr   = 0;
    int s_fe;
    int s_brk;
    int s_ovr;

    always @(negedge clk) begin
        if (uart_rx_frame_err) n_fe <= n_fe + 1;
        if (uart_rx_break)     n_brk <= n_brk + 1;
        if (uart_rx_overrun)   n_ovr <= n_ovr + 1;
    end

    typedef struct {
        logic [PB-1:0] d;
        logic          stop;
        logic          accept;
        logic          exp_valid;
        logic [PB-1:0] exp_data;
        int            exp_fe;
        int            exp_brk;
        int            exp_ovr;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic snap();
        s_fe  = n_fe;
        s_brk = n_brk;
        s_ovr = n_ovr;
    endtask

    task automatic check_flags(input string tag, input int fe, input int brk, input int ovr);
        check({tag, ".frame_err"}, n_fe - s_fe, fe);
        check({tag, ".break"}, n_brk - s_brk, brk);
        check({tag, ".overrun"}, n_ovr - s_ovr, ovr);
    endtask

    task automatic hold(input logic level, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            uart_rxd = level;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        uart_rx_ready = 1'b1;
        @(negedge clk);
        uart_rx_ready = 1'b0;
    endtask

    // Drives start, data (LSB first) and stop; optionally inverts one cycle of frame bit
    // spike_b at offset spike_off. valid_at = offset into the stop bit where valid is first seen.
    task automatic send_frame(input logic [PB-1:0] d, input logic stop, input int spike_b,
                              input int spike_off, output int valid_at);
        logic [PB+1:0] bits;
        bits = {stop, d, 1'b0};
        valid_at = -1;
        for (int b = 0; b < PB + 2; b++) begin
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                uart_rxd = bits[b] ^ ((b == spike_b) && (j == spike_off));
                if (b == PB + 1 && valid_at < 0 && uart_rx_valid) valid_at = j;
            end
        end
    endtask

    initial begin
        int            va;
        logic [PB-1:0] d;
        logic          stop;
        int            gap;
        logic          prev_bad;
        logic          m_valid;
        logic [PB-1:0] m_data;
        int            e_fe;
        int            e_brk;
        int            e_ovr;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 0, 0, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 0, 0, 0};
        vecs[2] = '{8'h96, 1'b1, 1'b0, 1'b1, 8'h96, 0, 0, 1};
        vecs[3] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'h96, 1, 0, 0};
        vecs[4] = '{8'h42, 1'b1, 1'b0, 1'b1, 8'h42, 0, 0, 0};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h42, 0, 1, 0};
        vecs[6] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 0, 0, 0};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 0, 1};
        vecs[8] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0, 0};
        vecs[9] = '{8'h80, 1'b0, 1'b0, 1'b1, 8'h00, 1, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.data", uart_rx_data, 0);
        check("reset.valid", uart_rx_valid, 0);
        check("reset.frame_err", uart_rx_frame_err, 0);
        check("reset.break", uart_rx_break, 0);
        check("reset.overrun", uart_rx_overrun, 0);
        rst_n = 1'b1;
        hold(1'b1, 10);

        // Latency: start seen 2 cycles after the pin, stop decided at counter HALF_BIT+1,
        // valid registered one edge later -> first visible 13 cycles into the stop bit.
        send_frame(8'h5A, 1'b1, -1, 0, va);
        check("timing.valid_at", va, 13);
        check("timing.data", uart_rx_data, 8'h5A);
        hold(1'b1, 4);
        @(negedge clk);
        uart_rx_ready = 1'b1;
        check("timing.valid_before_accept", uart_rx_valid, 1);
        @(negedge clk);
        uart_rx_ready = 1'b0;
        check("timing.valid_after_accept", uart_rx_valid, 0);

        // Table-driven frames
        for (int k = 0; k < 10; k++) begin
            if (vecs[k].accept) accept();
            snap();
            send_frame(vecs[k].d, vecs[k].stop, -1, 0, va);
            hold(1'b1, 8);
            check($sformatf("vec%0d.valid", k), uart_rx_valid, vecs[k].exp_valid);
            check($sformatf("vec%0d.data", k), uart_rx_data, vecs[k].exp_data);
            check_flags($sformatf("vec%0d", k), vecs[k].exp_fe, vecs[k].exp_brk, vecs[k].exp_ovr);
        end

        // Back-to-back frames with no idle time, second one overruns
        accept();
        snap();
        send_frame(8'h3C, 1'b1, -1, 0, va);
        send_frame(8'h96, 1'b1, -1, 0, va);
        hold(1'b1, 4);
        check("b2b.data", uart_rx_data, 8'h96);
        check("b2b.valid", uart_rx_valid, 1);
        check_flags("b2b", 0, 0, 1);

        // Line held low for 12 bit times: exactly one break, then recovery
        accept();
        snap();
        hold(1'b0, 12 * CPB);
        check("break.valid", uart_rx_valid, 0);
        check_flags("break", 0, 1, 0);
        hold(1'b1, 32);
        send_frame(8'h55, 1'b1, -1, 0, va);
        hold(1'b1, 4);
        check("break.next_valid", uart_rx_valid, 1);
        check("break.next_data", uart_rx_data, 8'h55);

        // Short start glitch rejected; single-cycle spike at data bit 3 centre outvoted
        accept();
        snap();
        hold(1'b0, 4);
        hold(1'b1, 40);
        check("glitch.valid", uart_rx_valid, 0);
        check_flags("glitch", 0, 0, 0);
        snap();
        send_frame(8'h00, 1'b1, 4, 9, va);
        hold(1'b1, 4);
        check("spike.valid", uart_rx_valid, 1);
        check("spike.data", uart_rx_data, 8'h00);
        check_flags("spike", 0, 0, 0);

        // Reset at the start of data bit 4 of 0xFF, with a byte pending
        accept();
        send_frame(8'hC3, 1'b1, -1, 0, va);
        hold(1'b1, 4);
        check("prerst.valid", uart_rx_valid, 1);
        check("prerst.data", uart_rx_data, 8'hC3);
        hold(1'b0, CPB);
        hold(1'b1, 4 * CPB);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.data", uart_rx_data, 0);
        check("midrst.valid", uart_rx_valid, 0);
        check("midrst.frame_err", uart_rx_frame_err, 0);
        check("midrst.break", uart_rx_break, 0);
        check("midrst.overrun", uart_rx_overrun, 0);
        rst_n = 1'b1;
        snap();
        hold(1'b1, 6 * CPB);
        check("postrst.valid", uart_rx_valid, 0);
        check_flags("postrst", 0, 0, 0);

        // Receive disabled for a whole frame
        uart_rx_en = 1'b0;
        snap();
        send_frame(8'hA5, 1'b1, -1, 0, va);
        hold(1'b1, 20);
        check("en_off.valid", uart_rx_valid, 0);
        check_flags("en_off", 0, 0, 0);
        uart_rx_en = 1'b1;
        send_frame(8'h33, 1'b1, -1, 0, va);
        hold(1'b1, 4);
        check("en_on.valid", uart_rx_valid, 1);
        check("en_on.data", uart_rx_data, 8'h33);

        // Random frames against a transaction-level model of the output register
        m_valid  = 1'b1;
        m_data   = 8'h33;
        prev_bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) d = '0;
            stop = ($urandom_range(0, 4) != 0);
            if (!prev_bad && $urandom_range(0, 3) == 0) gap = 0;
            else gap = $urandom_range(4, 24);
            if (gap >= 4 && $urandom_range(0, 1) == 1) begin
                accept();
                m_valid = 1'b0;
                hold(1'b1, gap - 2);
            end else begin
                hold(1'b1, gap);
            end
            e_fe  = 0;
            e_brk = 0;
            e_ovr = 0;
            if (stop) begin
                e_ovr   = m_valid ? 1 : 0;
                m_valid = 1'b1;
                m_data  = d;
            end else if (d == '0) begin
                e_brk = 1;
            end else begin
                e_fe = 1;
            end
            snap();
            send_frame(d, stop, -1, 0, va);
            check($sformatf("rand%0d.valid", k), uart_rx_valid, m_valid);
            check($sformatf("rand%0d.data", k), uart_rx_data, m_data);
            check_flags($sformatf("rand%0d", k), e_fe, e_brk, e_ovr);
            prev_bad = !stop;
        end
        hold(1'b1, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
